// File: rtl/nibbler_mem_pkg.sv
// rtl/nibbler_mem_pkg.sv - shared FSM state type for the self-clearing RAM
package nibbler_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - storage array with one synchronous write and one registered read port
module ram_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The array is deliberately not reset; only the clear sweep zeroes it.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - single-port RAM that sweeps itself to zero after reset or on request
module ram_sync_clr
  import nibbler_mem_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              csRAM,
  input  logic              weRAM,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              clr_req,
  output logic              busy
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_ptr == {ADDR_W{1'b1}}) state_next = IDLE;
      IDLE:    if (clr_req) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Pointer rests at 0 outside CLEAR so every sweep starts from the bottom.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
    end else begin
      clr_ptr <= '0;
    end
  end

  always_comb begin
    busy      = (state == CLEAR);
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = wdata;
    mem_re    = 1'b0;
    if (state == CLEAR) begin
      mem_we    = ~reset;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
    end else if (csRAM && !clr_req) begin
      mem_we = weRAM;
      mem_re = ~weRAM;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= mem_re;
    end
  end

  ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (mem_re),
    .raddr(address),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ram_sync_clr.sv
// tb/tb_ram_sync_clr.sv - directed table-driven bench for ram_sync_clr
module tb_ram_sync_clr;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0, we = 1'b0, clr = 1'b0;
  logic [3:0] addr = '0, wd = '0;
  logic [3:0] rd;
  logic       rv, busy;

  logic        reset2 = 1'b1;
  logic        cs2 = 1'b0, we2 = 1'b0, clr2 = 1'b0;
  logic [11:0] addr2 = '0;
  logic [3:0]  wd2 = '0;
  logic [3:0]  rd2;
  logic        rv2, busy2;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  ram_sync_clr #(.DATA_W(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .csRAM(cs), .weRAM(we), .address(addr),
    .wdata(wd), .rdata(rd), .rvalid(rv), .clr_req(clr), .busy(busy)
  );

  ram_sync_clr dut_big (
    .clock(clock), .reset(reset2), .csRAM(cs2), .weRAM(we2), .address(addr2),
    .wdata(wd2), .rdata(rd2), .rvalid(rv2), .clr_req(clr2), .busy(busy2)
  );

  typedef struct {
    logic       cs;
    logic       we;
    logic [3:0] addr;
    logic [3:0] wd;
    logic       exp_rv;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic w, input logic [3:0] a,
                      input logic [3:0] d, input logic cr);
    cs = c; we = w; addr = a; wd = d; clr = cr;
    @(posedge clock);
    #1;
  endtask

  // Count busy cycles while hammering the port with accesses that must be ignored.
  task automatic wait_busy(input string name, input int exp_n, input logic [3:0] hold_rd);
    int n = 0;
    while (busy === 1'b1 && n < exp_n + 8) begin
      chk({name, " rvalid during busy"}, int'(rv), 0);
      chk({name, " rdata held"}, int'(rd), int'(hold_rd));
      cs = 1'b1; we = n[0]; addr = n[3:0]; wd = 4'hF; clr = n[1];
      n++;
      @(posedge clock);
      #1;
    end
    cs = 1'b0; we = 1'b0; clr = 1'b0;
    chk({name, " busy cycles"}, n, exp_n);
  endtask

  task automatic read_all(input string name, input logic [3:0] exp);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
      chk($sformatf("%s rvalid[%0d]", name, i), int'(rv), 1);
      chk($sformatf("%s rdata[%0d]", name, i), int'(rd), int'(exp));
    end
  endtask

  task automatic fill_all(input logic [3:0] d);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 4'(i), d, 1'b0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'h3, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 1'b1, 4'h1, 4'hC, 1'b0, 4'h0};
    vecs[2]  = '{1'b1, 1'b1, 4'h2, 4'h6, 1'b0, 4'h0};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h3};
    vecs[4]  = '{1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 4'hC};
    vecs[5]  = '{1'b1, 1'b0, 4'h2, 4'h0, 1'b1, 4'h6};
    vecs[6]  = '{1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 4'h6};
    vecs[7]  = '{1'b1, 1'b1, 4'hA, 4'h9, 1'b0, 4'h6};
    vecs[8]  = '{1'b1, 1'b0, 4'hA, 4'h0, 1'b1, 4'h9};
    vecs[9]  = '{1'b1, 1'b1, 4'h5, 4'hF, 1'b0, 4'h9};
    vecs[10] = '{1'b0, 1'b1, 4'h5, 4'h0, 1'b0, 4'h9};
    vecs[11] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 4'hF};

    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", int'(busy), 1);
    chk("reset rvalid", int'(rv), 0);
    chk("reset rdata", int'(rd), 0);

    // Power-up clear
    reset = 1'b0;
    wait_busy("powerup", 16, 4'h0);
    read_all("powerup", 4'h0);

    // Write/read table
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].wd, 1'b0);
      chk($sformatf("vec%0d rvalid", i), int'(rv), int'(vecs[i].exp_rv));
      chk($sformatf("vec%0d rdata", i), int'(rd), int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d busy", i), int'(busy), 0);
    end

    // clr_req wins over a simultaneous read
    fill_all(4'hF);
    step(1'b1, 1'b0, 4'h3, 4'h0, 1'b0);
    chk("prefill read", int'(rd), 15);
    step(1'b1, 1'b0, 4'h5, 4'h0, 1'b1);
    chk("clr drop rvalid", int'(rv), 0);
    chk("clr rdata held", int'(rd), 15);
    wait_busy("clr_req", 16, 4'hF);
    read_all("after clr", 4'h0);

    // Reset at clear cycle 7 restarts the sweep
    fill_all(4'hF);
    step(1'b1, 1'b0, 4'h7, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 4'hE, 4'h8, 1'b0);
    chk("busy at cycle 7", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midclear reset rdata", int'(rd), 0);
    chk("midclear reset rvalid", int'(rv), 0);
    @(posedge clock);
    #1;
    chk("midclear reset busy", int'(busy), 1);
    reset = 1'b0;
    wait_busy("restart", 16, 4'h0);
    read_all("after restart", 4'h0);

    // Default-size instance
    chk("big reset busy", int'(busy2), 1);
    reset2 = 1'b0;
    begin
      int n = 0;
      while (busy2 === 1'b1 && n < 5000) begin
        n++;
        @(posedge clock);
        #1;
      end
      chk("big busy cycles", n, 4096);
    end
    cs2 = 1'b1; we2 = 1'b0; addr2 = 12'h000;
    @(posedge clock); #1;
    chk("big h000 rvalid", int'(rv2), 1);
    chk("big h000 rdata", int'(rd2), 0);
    we2 = 1'b1; addr2 = 12'h001; wd2 = 4'h7;
    @(posedge clock); #1;
    we2 = 1'b0;
    @(posedge clock); #1;
    chk("big h001 rdata", int'(rd2), 7);
    addr2 = 12'hFFF;
    @(posedge clock); #1;
    chk("big hFFF rvalid", int'(rv2), 1);
    chk("big hFFF rdata", int'(rd2), 0);
    cs2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
